// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding encodings and multiply/divide FSM state type
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } mdState_t;

endpackage

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_if;

  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       ResultSrcE0;
  logic       PCSrcE;
  logic       MulDivE;
  logic       MdDone;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       MdStart;
  logic       MdBusy;
  logic       MdTimeoutErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE, MdDone,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MdStart, MdBusy, MdTimeoutErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE, MdDone,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MdStart, MdBusy, MdTimeoutErr
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding select for one execute-stage source operand
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] fwdSel
);

  // The M-stage result is younger, so it wins over W; x0 is never forwarded.
  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and multiply/divide sequencing
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  mdState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             timeoutErr, timeoutErrNext;
  logic             mdStall, mdStartC;
  logic             lwStall;
  logic [1:0]       fwdA, fwdB;

  hazard_fwd_sel uFwdA (
    .rsE      (hz.Rs1E),
    .rdM      (hz.RdM),
    .rdW      (hz.RdW),
    .regWriteM(hz.RegWriteM),
    .regWriteW(hz.RegWriteW),
    .fwdSel   (fwdA)
  );

  hazard_fwd_sel uFwdB (
    .rsE      (hz.Rs2E),
    .rdM      (hz.RdM),
    .rdW      (hz.RdW),
    .regWriteM(hz.RegWriteM),
    .regWriteW(hz.RegWriteW),
    .fwdSel   (fwdB)
  );

  assign lwStall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                   ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MD_IDLE;
      cnt        <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      timeoutErr <= timeoutErrNext;
    end
  end

  // In the MdDone cycle the stall drops so the instruction moves to M on that edge.
  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    timeoutErrNext = timeoutErr;
    mdStall        = 1'b0;
    mdStartC       = 1'b0;
    case (state)
      MD_IDLE: begin
        if (hz.MulDivE) begin
          mdStartC  = 1'b1;
          mdStall   = 1'b1;
          cntNext   = '0;
          stateNext = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (hz.MdDone) begin
          stateNext = MD_IDLE;
        end else begin
          mdStall = 1'b1;
          cntNext = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            timeoutErrNext = 1'b1;
            stateNext      = MD_IDLE;
          end
        end
      end
      default: stateNext = MD_IDLE;
    endcase
  end

  assign hz.ForwardAE    = reset ? FWD_RF : fwdA;
  assign hz.ForwardBE    = reset ? FWD_RF : fwdB;
  assign hz.StallF       = !reset && (lwStall || mdStall);
  assign hz.StallD       = !reset && (lwStall || mdStall);
  assign hz.StallE       = !reset && mdStall;
  assign hz.FlushD       = reset || hz.PCSrcE;
  assign hz.FlushE       = reset || ((lwStall || hz.PCSrcE) && !mdStall);
  assign hz.FlushM       = reset || mdStall;
  assign hz.MdStart      = !reset && mdStartC;
  assign hz.MdBusy       = !reset && (state == MD_BUSY);
  assign hz.MdTimeoutErr = !reset && timeoutErr;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with MD_TIMEOUT = 4
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  typedef struct {
    string      tag;
    logic [3:0] fwd;    // {ForwardAE, ForwardBE}
    logic [2:0] stall;  // {StallF, StallD, StallE}
    logic [2:0] flush;  // {FlushD, FlushE, FlushM}
    logic [2:0] md;     // {MdStart, MdBusy, MdTimeoutErr}
  } expT;

  expT expQ[$];
  int  errCnt = 0;
  int  chkCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.RdM = 0; hz.RdW = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.ResultSrcE0 = 0; hz.PCSrcE = 0; hz.MulDivE = 0; hz.MdDone = 0;
  endtask

  // Inputs are already applied; queue the expectation, sample mid-cycle, then cross the edge.
  task automatic step(input string tag, input logic [3:0] fwd, input logic [2:0] stall,
                      input logic [2:0] flush, input logic [2:0] md);
    expT e;
    expT got;
    e.tag = tag; e.fwd = fwd; e.stall = stall; e.flush = flush; e.md = md;
    expQ.push_back(e);
    @(negedge clk);
    if (expQ.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      check({got.tag, ".fwd"},   32'({hz.ForwardAE, hz.ForwardBE}), 32'(got.fwd));
      check({got.tag, ".stall"}, 32'({hz.StallF, hz.StallD, hz.StallE}), 32'(got.stall));
      check({got.tag, ".flush"}, 32'({hz.FlushD, hz.FlushE, hz.FlushM}), 32'(got.flush));
      check({got.tag, ".md"},    32'({hz.MdStart, hz.MdBusy, hz.MdTimeoutErr}), 32'(got.md));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clearIn();
    @(posedge clk);
    #1;

    // Reset forces outputs even with hazards present
    hz.RegWriteM = 1; hz.RdM = 5; hz.Rs1E = 5; hz.MulDivE = 1; hz.PCSrcE = 1;
    step("reset", 4'b0000, 3'b000, 3'b111, 3'b000);
    reset = 1'b0;
    clearIn();
    step("idle", 4'b0000, 3'b000, 3'b000, 3'b000);

    // Forwarding
    hz.RdM = 5; hz.RegWriteM = 1; hz.Rs2E = 5; hz.RdW = 5; hz.RegWriteW = 1;
    step("fwdMprio", 4'b0010, 3'b000, 3'b000, 3'b000);
    hz.RdM = 0;
    step("fwdW", 4'b0001, 3'b000, 3'b000, 3'b000);
    clearIn();
    hz.Rs1E = 3; hz.RdW = 3; hz.RegWriteW = 1; hz.RdM = 3; hz.RegWriteM = 0;
    step("fwdAW", 4'b0100, 3'b000, 3'b000, 3'b000);
    clearIn();
    hz.RegWriteM = 1; hz.RegWriteW = 1;
    step("fwdX0", 4'b0000, 3'b000, 3'b000, 3'b000);
    hz.Rs1E = 9; hz.Rs2E = 9; hz.RdM = 9;
    step("fwdBothM", 4'b1010, 3'b000, 3'b000, 3'b000);
    clearIn();

    // Load-use
    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7;
    step("lwRs1", 4'b0000, 3'b110, 3'b010, 3'b000);
    clearIn();
    step("lwDone", 4'b0000, 3'b000, 3'b000, 3'b000);
    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7; hz.Rs1D = 2;
    step("lwRs2", 4'b0000, 3'b110, 3'b010, 3'b000);
    clearIn();
    hz.ResultSrcE0 = 1; hz.RdE = 0; hz.Rs1D = 0;
    step("lwX0", 4'b0000, 3'b000, 3'b000, 3'b000);
    clearIn();

    // Branch flush, alone and with a load-use
    hz.PCSrcE = 1;
    step("branch", 4'b0000, 3'b000, 3'b110, 3'b000);
    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7;
    step("lwBranch", 4'b0000, 3'b110, 3'b110, 3'b000);
    clearIn();

    // Multiply/divide, MdDone three cycles after start
    hz.MulDivE = 1; hz.RdM = 4; hz.RegWriteM = 1; hz.Rs1E = 4;
    step("mdStart", 4'b1000, 3'b111, 3'b001, 3'b100);
    hz.RegWriteM = 0;
    step("mdBusy1", 4'b0000, 3'b111, 3'b001, 3'b010);
    step("mdBusy2", 4'b0000, 3'b111, 3'b001, 3'b010);
    hz.MdDone = 1;
    step("mdDone", 4'b0000, 3'b000, 3'b000, 3'b010);
    clearIn();
    step("mdAfter", 4'b0000, 3'b000, 3'b000, 3'b000);
    hz.MdDone = 1;
    step("mdStrayDone", 4'b0000, 3'b000, 3'b000, 3'b000);
    clearIn();

    // Timeout with MD_TIMEOUT = 4
    hz.MulDivE = 1;
    step("toStart", 4'b0000, 3'b111, 3'b001, 3'b100);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("toBusy%0d", i), 4'b0000, 3'b111, 3'b001, 3'b010);
    end
    hz.MulDivE = 0;
    step("toErr", 4'b0000, 3'b000, 3'b000, 3'b001);
    step("toSticky", 4'b0000, 3'b000, 3'b000, 3'b001);
    hz.MdDone = 1;
    step("toStickyDone", 4'b0000, 3'b000, 3'b000, 3'b001);
    clearIn();
    reset = 1'b1;
    step("toReset", 4'b0000, 3'b000, 3'b111, 3'b000);
    reset = 1'b0;
    step("toCleared", 4'b0000, 3'b000, 3'b000, 3'b000);

    // Reset in the second BUSY cycle
    hz.MulDivE = 1;
    step("rbStart", 4'b0000, 3'b111, 3'b001, 3'b100);
    step("rbBusy1", 4'b0000, 3'b111, 3'b001, 3'b010);
    reset = 1'b1;
    step("rbReset", 4'b0000, 3'b000, 3'b111, 3'b000);
    step("rbReset2", 4'b0000, 3'b000, 3'b111, 3'b000);
    reset = 1'b0;
    hz.MulDivE = 0;
    step("rbIdle", 4'b0000, 3'b000, 3'b000, 3'b000);

    if (expQ.size() != 0) check("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
